ffn_block: RTL and testbench

FFN_BLOCK -- requirements
Module: ffn_block

---
 rtl/ffn_pkg.sv | 22 ++
 rtl/ffn_gelu_approx.sv | 36 +++
 rtl/ffn_block.sv | 103 ++++++++++
 tb/tb_ffn_block.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ffn_pkg.sv
// Shared constants, FSM state type and saturation helper for the FFN datapath.
package ffn_pkg;

  localparam int FRAC_BITS = 8;
  localparam int Q_ONE     = 256;
  localparam int GELU_LIM  = 3 * Q_ONE;
  localparam int INV6_Q8   = 43;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  // Clamp a wide signed value into the range of a dw-bit signed lane.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ffn_gelu_approx.sv
// Hidden-layer activation for one lane: GELU approximation when FFN_GELU_EN
// is defined, otherwise ReLU.
module gelu_approx
  import ffn_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [DATA_WIDTH-1:0] y
);

`ifdef FFN_GELU_EN
  localparam bit USE_GELU = 1'b1;
`else
  localparam bit USE_GELU = 1'b0;
`endif

  localparam int W = 2 * DATA_WIDTH + 8;

  logic signed [W-1:0]          xw, lim, sq, cub;
  logic signed [DATA_WIDTH-1:0] gelu_v, relu_v;

  always_comb begin
    xw  = W'(x);
    lim = W'(GELU_LIM);
    sq  = (xw * (xw + lim)) >>> FRAC_BITS;
    cub = (sq * W'(INV6_Q8)) >>> FRAC_BITS;
    if (xw <= -lim)     gelu_v = '0;
    else if (xw >= lim) gelu_v = x;
    else                gelu_v = DATA_WIDTH'(cub);
    relu_v = x[DATA_WIDTH-1] ? '0 : x;
  end

  assign y = USE_GELU ? gelu_v : relu_v;

endmodule

// File: rtl/ffn_block.sv
// Two-layer feed-forward block, one dot product per cycle; activation chosen
// by FFN_GELU_EN (see gelu_approx).
//   state | meaning
//   IDLE  | wait for valid_in, latch x_in
//   L1    | one hidden element per cycle, activated and stored
//   L2    | one output lane per cycle into the result buffer
//   DONE  | publish y_out, pulse valid_out
module ffn_block
  import ffn_pkg::*;
#(
  parameter int EMBED_DIM  = 4,
  parameter int FFN_DIM    = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      valid_in,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0]           x_in,
  input  logic [EMBED_DIM*FFN_DIM*DATA_WIDTH-1:0]   w1_flat,
  input  logic [FFN_DIM*DATA_WIDTH-1:0]             b1_flat,
  input  logic [FFN_DIM*EMBED_DIM*DATA_WIDTH-1:0]   w2_flat,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0]           b2_flat,
  output logic [EMBED_DIM*DATA_WIDTH-1:0]           y_out,
  output logic                                      valid_out
);

  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = 2 * DW + 8;
  localparam int MAXD  = (FFN_DIM > EMBED_DIM) ? FFN_DIM : EMBED_DIM;
  localparam int CW    = (MAXD > 1) ? $clog2(MAXD) : 1;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [EMBED_DIM*DW-1:0]  x_lat, y_buf;
  logic [FFN_DIM*DW-1:0]    h_buf;
  logic signed [ACC_W-1:0]  acc1, acc2;
  logic signed [DW-1:0]     h_pre, h_act, y_pre;

  // Both layers share the down-counter as their element index.
  always_comb begin
    acc1 = '0;
    for (int i = 0; i < EMBED_DIM; i++)
      acc1 = acc1 + ACC_W'($signed(x_lat[i*DW +: DW]))
                  * ACC_W'($signed(w1_flat[(i*FFN_DIM + int'(cnt))*DW +: DW]));
    h_pre = DW'(sat_dw(64'(acc1 >>> FRAC_BITS)
                       + 64'($signed(b1_flat[int'(cnt)*DW +: DW])), DW));

    acc2 = '0;
    for (int r = 0; r < FFN_DIM; r++)
      acc2 = acc2 + ACC_W'($signed(h_buf[r*DW +: DW]))
                  * ACC_W'($signed(w2_flat[(r*EMBED_DIM + int'(cnt))*DW +: DW]));
    y_pre = DW'(sat_dw(64'(acc2 >>> FRAC_BITS)
                       + 64'($signed(b2_flat[int'(cnt)*DW +: DW])), DW));
  end

  gelu_approx #(.DATA_WIDTH(DW)) u_act (
    .x (h_pre),
    .y (h_act)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      x_lat     <= '0;
      h_buf     <= '0;
      y_buf     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: if (valid_in) begin
          x_lat <= x_in;
          cnt   <= CW'(FFN_DIM - 1);
          state <= L1;
        end
        L1: begin
          h_buf[int'(cnt)*DW +: DW] <= h_act;
          if (cnt == '0) begin
            cnt   <= CW'(EMBED_DIM - 1);
            state <= L2;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        L2: begin
          y_buf[int'(cnt)*DW +: DW] <= y_pre;
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CW'(1);
        end
        // y_out only changes here so it holds the previous result during L2.
        DONE: begin
          y_out     <= y_buf;
          valid_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffn_block.sv
// Scoreboard bench for ffn_block: an arithmetic reference model pushes expected
// results at issue time, a monitor pops and compares on every valid_out.
module tb_ffn_block;

  localparam int E   = 4;
  localparam int F   = 8;
  localparam int DW  = 16;
  localparam int LAT = F + E + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid_in = 1'b0;
  logic [E*DW-1:0]   x_in = '0;
  logic [E*F*DW-1:0] w1_flat = '0;
  logic [F*DW-1:0]   b1_flat = '0;
  logic [F*E*DW-1:0] w2_flat = '0;
  logic [E*DW-1:0]   b2_flat = '0;
  logic [E*DW-1:0]   y_out;
  logic              valid_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int w1[E][F];
  int b1[F];
  int w2[F][E];
  int b2[E];

  logic [E*DW-1:0] exp_y[$];
  int              exp_cap[$];

  ffn_block #(.EMBED_DIM(E), .FFN_DIM(F), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .x_in      (x_in),
    .w1_flat   (w1_flat),
    .b1_flat   (b1_flat),
    .w2_flat   (w2_flat),
    .b2_flat   (b2_flat),
    .y_out     (y_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int act(input int v);
`ifdef FFN_GELU_EN
    if (v <= -768) return 0;
    if (v >= 768)  return v;
    return (((v * (v + 768)) >>> 8) * 43) >>> 8;
`else
    return (v < 0) ? 0 : v;
`endif
  endfunction

  function automatic logic [E*DW-1:0] model(input int x[E]);
    longint          acc;
    int              h[F];
    logic [E*DW-1:0] y;
    y = '0;
    for (int k = 0; k < F; k++) begin
      acc = 0;
      for (int i = 0; i < E; i++) acc += longint'(x[i]) * longint'(w1[i][k]);
      h[k] = act(int'(sat16((acc >>> 8) + longint'(b1[k]))));
    end
    for (int c = 0; c < E; c++) begin
      acc = 0;
      for (int r = 0; r < F; r++) acc += longint'(h[r]) * longint'(w2[r][c]);
      y[c*DW +: DW] = DW'(sat16((acc >>> 8) + longint'(b2[c])));
    end
    return y;
  endfunction

  task automatic clear_params();
    for (int i = 0; i < E; i++) for (int k = 0; k < F; k++) w1[i][k] = 0;
    for (int r = 0; r < F; r++) for (int c = 0; c < E; c++) w2[r][c] = 0;
    for (int k = 0; k < F; k++) b1[k] = 0;
    for (int c = 0; c < E; c++) b2[c] = 0;
  endtask

  task automatic identity();
    clear_params();
    for (int i = 0; i < E; i++) begin
      w1[i][i] = 256;
      w2[i][i] = 256;
    end
  endtask

  task automatic load_params();
    for (int r = 0; r < E; r++)
      for (int c = 0; c < F; c++) w1_flat[(r*F + c)*DW +: DW] = DW'(w1[r][c]);
    for (int r = 0; r < F; r++)
      for (int c = 0; c < E; c++) w2_flat[(r*E + c)*DW +: DW] = DW'(w2[r][c]);
    for (int k = 0; k < F; k++) b1_flat[k*DW +: DW] = DW'(b1[k]);
    for (int c = 0; c < E; c++) b2_flat[c*DW +: DW] = DW'(b2[c]);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic issue(input int x[E]);
    @(negedge clk);
    for (int i = 0; i < E; i++) x_in[i*DW +: DW] = DW'(x[i]);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    exp_y.push_back(model(x));
    exp_cap.push_back(cyc);
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_y.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_y.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d expected 0", exp_y.size());
      exp_y.delete();
      exp_cap.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst && valid_out) begin
      if (exp_y.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_out y_out=%h expected no pulse", y_out);
      end else begin
        logic [E*DW-1:0] ey;
        int              cap;
        ey  = exp_y.pop_front();
        cap = exp_cap.pop_front();
        chk("y_out", 64'(y_out), 64'(ey));
        chk("latency", 64'(cyc - cap), 64'(LAT));
      end
    end
  end

  initial begin
    int xv[E];
    int n;

    repeat (3) @(negedge clk);
    chk("reset_y_out", 64'(y_out), 64'd0);
    chk("reset_valid_out", 64'(valid_out), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    identity(); load_params();
    xv = '{1536, 1280, 768, 1024}; issue(xv); wait_idle();
    xv = '{-1024, 0, 256, -256};   issue(xv); wait_idle();

    clear_params(); w1[0][0] = 32767; w2[0][0] = 256; w2[1][1] = 256; load_params();
    xv = '{32767, 0, 0, 0}; issue(xv); wait_idle();
    w2[0][0] = -32768; load_params();
    issue(xv); wait_idle();

    clear_params();
    for (int k = 0; k < F; k++) b1[k] = 256;
    b2 = '{256, 512, -256, 0};
    load_params();
    xv = '{1000, -1000, 77, 5}; issue(xv); wait_idle();

    for (int t = 0; t < 24; t++) begin
      int span;
      span = (t % 3 == 0) ? 65536 : 1024;
      for (int i = 0; i < E; i++) for (int k = 0; k < F; k++)
        w1[i][k] = int'($urandom_range(0, span - 1)) - span / 2;
      for (int r = 0; r < F; r++) for (int c = 0; c < E; c++)
        w2[r][c] = int'($urandom_range(0, span - 1)) - span / 2;
      for (int k = 0; k < F; k++) b1[k] = int'($urandom_range(0, 2047)) - 1024;
      for (int c = 0; c < E; c++) b2[c] = int'($urandom_range(0, 2047)) - 1024;
      for (int i = 0; i < E; i++) xv[i] = int'($urandom_range(0, 4095)) - 2048;
      load_params();
      issue(xv);
      wait_idle();
    end

    // valid_in pulsed during L1 must be dropped
    identity(); load_params();
    xv = '{700, -300, 1200, 50}; issue(xv);
    repeat (3) @(negedge clk);
    x_in = {4{16'sd512}};
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // reset in the middle of L2
    xv = '{300, 400, 500, 600}; issue(xv);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_y_out", 64'(y_out), 64'd0);
    chk("midreset_valid_out", 64'(valid_out), 64'd0);
    exp_y.delete();
    exp_cap.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_y_out", 64'(y_out), 64'd0);

    // back-to-back: new valid_in the cycle after valid_out
    xv = '{256, 512, 768, 1024}; issue(xv);
    n = 0;
    while (!valid_out && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!valid_out) begin
      checks++;
      errors++;
      $display("FAIL b2b_wait valid_out=%0b expected 1", valid_out);
    end
    xv = '{-512, 900, 0, 333}; issue(xv);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
